// File: rtl/cdb_arbiter_if.sv
// CDB_IF: common data bus broadcast bundle.
//   master : driven by the CDB arbiter (valid + result fields)
//   slave  : observed by the register file write port, RS wakeup, ROB completion
interface CDB_IF #(
    parameter int PHYSICAL_REG_NUM_WIDTH = 6,
    parameter int REG_VAL_WIDTH          = 32,
    parameter int ROB_SIZE_WIDTH         = 5
);
    logic                              valid;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] register_addr;
    logic [REG_VAL_WIDTH-1:0]          register_val;
    logic [ROB_SIZE_WIDTH-1:0]         inst_tag;

    modport master (
        output valid,
        output register_addr,
        output register_val,
        output inst_tag
    );

    modport slave (
        input valid,
        input register_addr,
        input register_val,
        input inst_tag
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers completed results from NUM_SRC functional units in
// small per-source FIFOs and broadcasts at most one per cycle on the CDB,
// chosen by a round-robin arbiter. The CDB outputs are registered.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low; clears all state, forces fu_ready low
//   flush        drops all buffered results and the pending broadcast
//   fu_valid     per-source result valid
//   fu_ready     per-source can-accept (registered FIFO count only)
//   fu_reg_addr  packed destination physical registers, source i at slice i
//   fu_reg_val   packed result values
//   fu_inst_tag  packed ROB tags
//   CDB_if       CDB_IF.master broadcast port
module cdb_arbiter #(
    parameter int NUM_SRC                = 4,
    parameter int FIFO_DEPTH             = 2,
    parameter int PHYSICAL_REG_NUM_WIDTH = 6,
    parameter int REG_VAL_WIDTH          = 32,
    parameter int ROB_SIZE_WIDTH         = 5
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      flush,
    input  logic [NUM_SRC-1:0]                        fu_valid,
    output logic [NUM_SRC-1:0]                        fu_ready,
    input  logic [NUM_SRC*PHYSICAL_REG_NUM_WIDTH-1:0] fu_reg_addr,
    input  logic [NUM_SRC*REG_VAL_WIDTH-1:0]          fu_reg_val,
    input  logic [NUM_SRC*ROB_SIZE_WIDTH-1:0]         fu_inst_tag,
    CDB_IF.master                                     CDB_if
);

    localparam int          AW   = PHYSICAL_REG_NUM_WIDTH;
    localparam int          VW   = REG_VAL_WIDTH;
    localparam int          TW   = ROB_SIZE_WIDTH;
    localparam int          PW   = $clog2(FIFO_DEPTH);
    localparam int          CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int          SW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned NSRC = NUM_SRC;

    // FIFO storage (no reset needed: only entries below count are ever read)
    logic [AW-1:0] mem_addr [NUM_SRC][FIFO_DEPTH];
    logic [VW-1:0] mem_val  [NUM_SRC][FIFO_DEPTH];
    logic [TW-1:0] mem_tag  [NUM_SRC][FIFO_DEPTH];

    logic [PW-1:0] rd_ptr [NUM_SRC];
    logic [PW-1:0] wr_ptr [NUM_SRC];
    logic [CW-1:0] count  [NUM_SRC];

    logic [SW-1:0]      rr_ptr;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               gnt_valid;
    logic [SW-1:0]      gnt_idx;
    logic [SW-1:0]      rr_next;

    // Ready comes from the registered count alone; reset gates it low.
    always_comb begin
        fu_ready = '0;
        req      = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            fu_ready[i] = reset && (count[i] < CW'(FIFO_DEPTH));
            req[i]      = (count[i] != '0);
        end
    end

    // Round-robin search starting at rr_ptr; first non-empty FIFO wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            idx = (32'(rr_ptr) + k) % NSRC;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SW'(idx);
            end
        end
        rr_next = (gnt_idx == SW'(NSRC - 1)) ? '0 : gnt_idx + SW'(1);
    end

    always_comb begin
        push = '0;
        pop  = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            push[i] = fu_valid[i] && fu_ready[i] && !flush;
            pop[i]  = gnt_valid && (gnt_idx == SW'(i));
        end
    end

    // FIFO pointers and counts. A full FIFO refuses pushes, so a pop from a
    // full FIFO only frees the slot for the following cycle.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (push[i]) begin
                mem_addr[i][wr_ptr[i]] <= fu_reg_addr[i*AW +: AW];
                mem_val[i][wr_ptr[i]]  <= fu_reg_val[i*VW +: VW];
                mem_tag[i][wr_ptr[i]]  <= fu_inst_tag[i*TW +: TW];
            end
        end
    end

    // Registered CDB broadcast and round-robin pointer. Flush kills the
    // pending broadcast but leaves rr_ptr alone; reset clears both.
    always_ff @(posedge clk) begin
        if (!reset) begin
            CDB_if.valid         <= 1'b0;
            CDB_if.register_addr <= '0;
            CDB_if.register_val  <= '0;
            CDB_if.inst_tag      <= '0;
            rr_ptr               <= '0;
        end else if (flush) begin
            CDB_if.valid <= 1'b0;
        end else if (gnt_valid) begin
            CDB_if.valid         <= 1'b1;
            CDB_if.register_addr <= mem_addr[gnt_idx][rd_ptr[gnt_idx]];
            CDB_if.register_val  <= mem_val[gnt_idx][rd_ptr[gnt_idx]];
            CDB_if.inst_tag      <= mem_tag[gnt_idx][rd_ptr[gnt_idx]];
            rr_ptr               <= rr_next;
        end else begin
            CDB_if.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int NS = 4;
    localparam int AW = 6;
    localparam int VW = 32;
    localparam int TW = 5;

    logic              clk;
    logic              reset;
    logic              flush;
    logic [NS-1:0]     fu_valid;
    logic [NS-1:0]     fu_ready;
    logic [NS*AW-1:0]  fu_reg_addr;
    logic [NS*VW-1:0]  fu_reg_val;
    logic [NS*TW-1:0]  fu_inst_tag;

    int n_checks = 0;
    int n_fail   = 0;

    CDB_IF #(.PHYSICAL_REG_NUM_WIDTH(AW), .REG_VAL_WIDTH(VW), .ROB_SIZE_WIDTH(TW)) cdb ();

    cdb_arbiter #(
        .NUM_SRC(NS),
        .FIFO_DEPTH(2),
        .PHYSICAL_REG_NUM_WIDTH(AW),
        .REG_VAL_WIDTH(VW),
        .ROB_SIZE_WIDTH(TW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .fu_valid(fu_valid),
        .fu_ready(fu_ready),
        .fu_reg_addr(fu_reg_addr),
        .fu_reg_val(fu_reg_val),
        .fu_inst_tag(fu_inst_tag),
        .CDB_if(cdb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cdb(input string tag, input logic [AW-1:0] a,
                             input logic [VW-1:0] v, input logic [TW-1:0] t);
        check({tag, ".valid"}, 64'(cdb.valid), 64'(1'b1));
        check({tag, ".addr"},  64'(cdb.register_addr), 64'(a));
        check({tag, ".val"},   64'(cdb.register_val), 64'(v));
        check({tag, ".tag"},   64'(cdb.inst_tag), 64'(t));
    endtask

    task automatic drive(input int src, input logic [AW-1:0] a,
                         input logic [VW-1:0] v, input logic [TW-1:0] t);
        fu_reg_addr[src*AW +: AW] = a;
        fu_reg_val[src*VW +: VW]  = v;
        fu_inst_tag[src*TW +: TW] = t;
    endtask

    initial begin
        reset       = 1'b0;
        flush       = 1'b0;
        fu_valid    = 4'b1111;
        fu_reg_addr = '1;
        fu_reg_val  = '1;
        fu_inst_tag = '1;

        // Reset held two cycles with all sources requesting
        tick();
        tick();
        check("rst.ready", 64'(fu_ready), 64'(4'b0000));
        check("rst.valid", 64'(cdb.valid), 64'(1'b0));
        check("rst.addr",  64'(cdb.register_addr), 64'(0));
        check("rst.val",   64'(cdb.register_val), 64'(0));
        check("rst.tag",   64'(cdb.inst_tag), 64'(0));
        fu_valid = '0;
        reset    = 1'b1;
        tick();
        check("rel.ready", 64'(fu_ready), 64'(4'b1111));
        check("rel.valid", 64'(cdb.valid), 64'(1'b0));

        // Single result from source 2
        drive(2, 6'd7, 32'hDEADBEEF, 5'd3);
        fu_valid = 4'b0100;
        tick();
        check("single.nobypass", 64'(cdb.valid), 64'(1'b0));
        fu_valid = '0;
        tick();
        check_cdb("single", 6'd7, 32'hDEADBEEF, 5'd3);
        tick();
        check("single.after", 64'(cdb.valid), 64'(1'b0));
        check("single.hold",  64'(cdb.register_addr), 64'(7));

        // rr_ptr is 3 now: a lone source-3 result wins and wraps rr_ptr to 0
        drive(3, 6'd9, 32'h12345678, 5'd1);
        fu_valid = 4'b1000;
        tick();
        fu_valid = '0;
        tick();
        check_cdb("src3", 6'd9, 32'h12345678, 5'd1);

        // Round-robin: all four push together, rr_ptr = 0
        for (int i = 0; i < NS; i++) drive(i, AW'(10 + i), VW'(32'h100 + i), TW'(i));
        fu_valid = 4'b1111;
        tick();
        fu_valid = '0;
        tick();
        check_cdb("rr0", 6'd10, 32'h100, 5'd0);
        tick();
        check_cdb("rr1", 6'd11, 32'h101, 5'd1);
        tick();
        check_cdb("rr2", 6'd12, 32'h102, 5'd2);
        tick();
        check_cdb("rr3", 6'd13, 32'h103, 5'd3);
        tick();
        check("rr.idle", 64'(cdb.valid), 64'(1'b0));

        // Backpressure on source 1 (rr_ptr = 0)
        drive(0, 6'd20, 32'hA000, 5'd0);
        drive(1, 6'd30, 32'hB000, 5'd8);
        fu_valid = 4'b0011;
        tick();
        check("bp.e1", 64'(cdb.valid), 64'(1'b0));
        drive(0, 6'd21, 32'hA001, 5'd1);
        drive(1, 6'd31, 32'hB001, 5'd9);
        tick();
        check_cdb("bp.a0", 6'd20, 32'hA000, 5'd0);
        check("bp.full1", 64'(fu_ready), 64'(4'b1101));
        fu_valid = 4'b0010;
        drive(1, 6'd32, 32'hB002, 5'd10);
        tick();
        check_cdb("bp.b0", 6'd30, 32'hB000, 5'd8);
        check("bp.room1", 64'(fu_ready), 64'(4'b1111));
        tick();
        check_cdb("bp.a1", 6'd21, 32'hA001, 5'd1);
        check("bp.full1b", 64'(fu_ready), 64'(4'b1101));
        fu_valid = '0;
        tick();
        check_cdb("bp.b1", 6'd31, 32'hB001, 5'd9);
        tick();
        check_cdb("bp.b2", 6'd32, 32'hB002, 5'd10);
        tick();
        check("bp.idle", 64'(cdb.valid), 64'(1'b0));

        // Flush (rr_ptr = 2): source 2 drains first, leaving 2 in src3 and 1 in src0
        drive(2, 6'd50, 32'hF200, 5'd20);
        drive(3, 6'd51, 32'hF300, 5'd21);
        drive(0, 6'd52, 32'hF000, 5'd22);
        fu_valid = 4'b1101;
        tick();
        drive(3, 6'd53, 32'hF301, 5'd23);
        fu_valid = 4'b1000;
        tick();
        check_cdb("fl.z0", 6'd50, 32'hF200, 5'd20);
        drive(1, 6'd54, 32'hF100, 5'd24);
        fu_valid = 4'b0010;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        fu_valid = '0;
        check("fl.valid", 64'(cdb.valid), 64'(1'b0));
        check("fl.ready", 64'(fu_ready), 64'(4'b1111));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fl.quiet", 64'(cdb.valid), 64'(1'b0));
        end

        // rr_ptr kept at 3 across flush: source 3 beats source 0
        drive(0, 6'd60, 32'h6000, 5'd2);
        drive(3, 6'd61, 32'h6003, 5'd4);
        fu_valid = 4'b1001;
        tick();
        fu_valid = '0;
        tick();
        check_cdb("rrkeep.s3", 6'd61, 32'h6003, 5'd4);
        tick();
        check_cdb("rrkeep.s0", 6'd60, 32'h6000, 5'd2);
        tick();
        check("rrkeep.idle", 64'(cdb.valid), 64'(1'b0));

        // Pointer wrap: 8 back-to-back pushes on source 0
        fu_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            drive(0, AW'(40 + k), VW'(32'hC0DE0000 + k), TW'(16 + k));
            tick();
            if (k > 0) check_cdb("wrap", AW'(40 + k - 1), VW'(32'hC0DE0000 + k - 1), TW'(16 + k - 1));
            else check("wrap.first", 64'(cdb.valid), 64'(1'b0));
        end
        fu_valid = '0;
        tick();
        check_cdb("wrap.last", 6'd47, 32'hC0DE0007, 5'd23);
        tick();
        check("wrap.idle", 64'(cdb.valid), 64'(1'b0));

        // Reset mid-operation discards a pending result and clears rr_ptr
        drive(1, 6'd33, 32'h7001, 5'd5);
        fu_valid = 4'b0010;
        tick();
        drive(2, 6'd34, 32'h7002, 5'd6);
        fu_valid = 4'b0100;
        reset    = 1'b0;
        tick();
        check("mrst.valid", 64'(cdb.valid), 64'(1'b0));
        check("mrst.addr",  64'(cdb.register_addr), 64'(0));
        check("mrst.val",   64'(cdb.register_val), 64'(0));
        check("mrst.tag",   64'(cdb.inst_tag), 64'(0));
        check("mrst.ready", 64'(fu_ready), 64'(4'b0000));
        reset    = 1'b1;
        fu_valid = '0;
        tick();
        check("mrst.rel.ready", 64'(fu_ready), 64'(4'b1111));
        check("mrst.rel.valid", 64'(cdb.valid), 64'(1'b0));
        drive(0, 6'd1, 32'h8000, 5'd11);
        drive(3, 6'd2, 32'h8003, 5'd12);
        fu_valid = 4'b1001;
        tick();
        fu_valid = '0;
        tick();
        check_cdb("mrst.s0", 6'd1, 32'h8000, 5'd11);
        tick();
        check_cdb("mrst.s3", 6'd2, 32'h8003, 5'd12);
        tick();
        check("mrst.idle", 64'(cdb.valid), 64'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
